vga_row_display: RTL and testbench

Downstream display stage for the tiny Mandelbrot engine. It accepts 4-bit iteration counters, one per pixel, over a valid/ready stream and holds them in a ping-pong pair of row buffers. It generates 640x480@60 VGA timing and drives the RGB222 and sync signals that feed the top-level `uo_out` mux in VGA mode. The engine computes row N+1 while row N is displayed.

---
 rtl/vga_row_display_pkg.sv | 50 +++++
 rtl/vga_row_display_timing.sv | 89 ++++++++
 rtl/vga_row_display.sv | 136 +++++++++++++
 tb/tb_vga_row_display.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_row_display_pkg.sv
// Shared timing defaults, counter widths, pixel colour type and colour map for the VGA row display.
// VGA_PALETTE_EN selects the 16-entry colour table; otherwise pixels map to grayscale.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE     = 640;
  localparam int unsigned DEF_H_FP         = 16;
  localparam int unsigned DEF_H_SYNC       = 96;
  localparam int unsigned DEF_H_BP         = 48;
  localparam int unsigned DEF_V_ACTIVE     = 480;
  localparam int unsigned DEF_V_FP         = 10;
  localparam int unsigned DEF_V_SYNC       = 2;
  localparam int unsigned DEF_V_BP         = 33;
  localparam int unsigned DEF_PIXEL_REPEAT = 10;
  localparam int unsigned DEF_ROW_REPEAT   = 10;
  localparam int unsigned ROW_PIXELS       = 64;

  localparam int unsigned H_W    = 10;
  localparam int unsigned V_W    = 10;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned COL_W  = 6;
  localparam int unsigned PX_W   = 4;
  localparam int unsigned LIR_W  = 4;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

`ifdef VGA_PALETTE_EN
  // Dark-to-bright ramp through blue, cyan, yellow and red; entry 0 black, entry 15 white.
  localparam logic [5:0] PALETTE [16] = '{
    6'h00, 6'h01, 6'h02, 6'h03, 6'h07, 6'h0B, 6'h0F, 6'h1F,
    6'h2F, 6'h3E, 6'h3C, 6'h38, 6'h34, 6'h30, 6'h2A, 6'h3F
  };
`endif

  function automatic rgb222_t color_map(input logic [DATA_W-1:0] d);
    rgb222_t c;
`ifdef VGA_PALETTE_EN
    c = rgb222_t'(PALETTE[d]);
`else
    c.r = 2'(d >> 2);
    c.g = c.r;
    c.b = c.r;
`endif
    return c;
  endfunction

endpackage

// File: rtl/vga_row_display_timing.sv
// VGA raster counters with sync, active-area, row-swap and frame-start strobes derived from them.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned H_FP         = DEF_H_FP,
  parameter int unsigned H_SYNC       = DEF_H_SYNC,
  parameter int unsigned H_BP         = DEF_H_BP,
  parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
  parameter int unsigned V_FP         = DEF_V_FP,
  parameter int unsigned V_SYNC       = DEF_V_SYNC,
  parameter int unsigned V_BP         = DEF_V_BP,
  parameter int unsigned PIXEL_REPEAT = DEF_PIXEL_REPEAT,
  parameter int unsigned ROW_REPEAT   = DEF_ROW_REPEAT
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [COL_W-1:0] o_col,
  output logic             o_active_c,
  output logic             o_hsync_c,
  output logic             o_vsync_c,
  output logic             o_swap_c,
  output logic             o_frame_start_c
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_W-1:0]   H_ACT_L    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   H_LAST_L   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   HS_BEG_L   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   HS_END_L   = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0]   V_ACT_L    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   V_ACT_M1_L = V_W'(V_ACTIVE - 1);
  localparam logic [V_W-1:0]   V_LAST_L   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   VS_BEG_L   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   VS_END_L   = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [PX_W-1:0]  PX_LAST_L  = PX_W'(PIXEL_REPEAT - 1);
  localparam logic [LIR_W-1:0] LIR_LAST_L = LIR_W'(ROW_REPEAT - 1);

  logic [H_W-1:0]   r_h;
  logic [V_W-1:0]   r_v;
  logic [PX_W-1:0]  r_px;
  logic [COL_W-1:0] r_col;
  logic [LIR_W-1:0] r_lir;
  logic             w_h_last;
  logic             w_v_last;

  assign w_h_last = (r_h == H_LAST_L);
  assign w_v_last = (r_v == V_LAST_L);

  assign o_col           = r_col;
  assign o_active_c      = (r_h < H_ACT_L) && (r_v < V_ACT_L);
  assign o_hsync_c       = !((r_h >= HS_BEG_L) && (r_h <= HS_END_L));
  assign o_vsync_c       = !((r_v >= VS_BEG_L) && (r_v <= VS_END_L));
  assign o_frame_start_c = (r_h == '0) && (r_v == V_ACT_L);
  // Swap on the line whose successor begins a new row group.
  assign o_swap_c        = (r_h == H_ACT_L) &&
                           (w_v_last || ((r_v < V_ACT_M1_L) && (r_lir == LIR_LAST_L)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h   <= '0;
      r_v   <= '0;
      r_px  <= '0;
      r_col <= '0;
      r_lir <= '0;
    end else if (w_h_last) begin
      r_h   <= '0;
      r_px  <= '0;
      r_col <= '0;
      r_v   <= w_v_last ? '0 : r_v + 1'b1;
      if (r_v < V_ACT_L) begin
        r_lir <= (r_lir == LIR_LAST_L) ? '0 : r_lir + 1'b1;
      end
    end else begin
      r_h <= r_h + 1'b1;
      if (o_active_c) begin
        if (r_px == PX_LAST_L) begin
          r_px  <= '0;
          r_col <= r_col + 1'b1;
        end else begin
          r_px <= r_px + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_row_display.sv
// VGA row display: ping-pong 64-pixel row banks filled over valid/ready and shown on a VGA raster.
// Define VGA_PALETTE_EN for the 16-entry colour table; the default build shows grayscale.
module vga_row_display
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned H_FP         = DEF_H_FP,
  parameter int unsigned H_SYNC       = DEF_H_SYNC,
  parameter int unsigned H_BP         = DEF_H_BP,
  parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
  parameter int unsigned V_FP         = DEF_V_FP,
  parameter int unsigned V_SYNC       = DEF_V_SYNC,
  parameter int unsigned V_BP         = DEF_V_BP,
  parameter int unsigned PIXEL_REPEAT = DEF_PIXEL_REPEAT,
  parameter int unsigned ROW_REPEAT   = DEF_ROW_REPEAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [1:0]        R,
  output logic [1:0]        G,
  output logic [1:0]        B,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start,
  output logic              underrun
);

  localparam logic [COL_W-1:0] IDX_LAST = COL_W'(ROW_PIXELS - 1);

  logic [COL_W-1:0]  w_col;
  logic              w_active;
  logic              w_hsync;
  logic              w_vsync;
  logic              w_swap;
  logic              w_frame_start;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_pix;
  rgb222_t           w_rgb;

  logic [DATA_W-1:0] r_bank0 [ROW_PIXELS];
  logic [DATA_W-1:0] r_bank1 [ROW_PIXELS];
  logic              r_disp_sel;
  logic              r_fill_full;
  logic [COL_W-1:0]  r_wr_idx;

  vga_timing #(
    .H_ACTIVE     (H_ACTIVE),
    .H_FP         (H_FP),
    .H_SYNC       (H_SYNC),
    .H_BP         (H_BP),
    .V_ACTIVE     (V_ACTIVE),
    .V_FP         (V_FP),
    .V_SYNC       (V_SYNC),
    .V_BP         (V_BP),
    .PIXEL_REPEAT (PIXEL_REPEAT),
    .ROW_REPEAT   (ROW_REPEAT)
  ) u_timing (
    .clk             (clk),
    .rst_n           (rst_n),
    .o_col           (w_col),
    .o_active_c      (w_active),
    .o_hsync_c       (w_hsync),
    .o_vsync_c       (w_vsync),
    .o_swap_c        (w_swap),
    .o_frame_start_c (w_frame_start)
  );

  // A write landing on the frame-start cycle is dropped by the clear.
  assign wr_ready = ~r_fill_full;
  assign w_wr_en  = wr_valid & ~r_fill_full & ~w_frame_start;
  assign w_pix    = r_disp_sel ? r_bank1[w_col] : r_bank0[w_col];
  assign w_rgb    = color_map(w_pix);

  // The bank not selected for display is the fill bank; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en && r_disp_sel) begin
      r_bank0[r_wr_idx] <= wr_data;
    end
    if (w_wr_en && !r_disp_sel) begin
      r_bank1[r_wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx    <= '0;
      r_fill_full <= 1'b0;
      r_disp_sel  <= 1'b0;
      underrun    <= 1'b0;
    end else if (w_frame_start) begin
      r_wr_idx    <= '0;
      r_fill_full <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (w_wr_en) begin
        if (r_wr_idx == IDX_LAST) begin
          r_fill_full <= 1'b1;
          r_wr_idx    <= '0;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
      // Swap decision uses the registered full flag, so a same-cycle last write is an underrun.
      if (w_swap) begin
        if (r_fill_full) begin
          r_disp_sel  <= ~r_disp_sel;
          r_fill_full <= 1'b0;
        end else begin
          underrun <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R           <= 2'b00;
      G           <= 2'b00;
      B           <= 2'b00;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      R           <= w_active ? w_rgb.r : 2'b00;
      G           <= w_active ? w_rgb.g : 2'b00;
      B           <= w_active ? w_rgb.b : 2'b00;
      hsync       <= w_hsync;
      vsync       <= w_vsync;
      frame_start <= w_frame_start;
    end
  end

endmodule

// File: tb/tb_vga_row_display.sv
// Randomized self-checking bench for vga_row_display on a shrunken raster, with a frame-level model.
module tb_vga_row_display;

  localparam int unsigned PR = 2, RR = 3;
  localparam int unsigned HA = 128, HFP = 4, HS = 12, HBP = 8;
  localparam int unsigned VA = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int unsigned HT = HA + HFP + HS + HBP;
  localparam int unsigned VT = VA + VFP + VS + VBP;
  localparam int unsigned FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_data = 4'd0;
  logic       wr_ready;
  logic [1:0] R, G, B;
  logic       hsync, vsync, frame_start, underrun;

  vga_row_display #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .PIXEL_REPEAT(PR), .ROW_REPEAT(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .R(R), .G(G), .B(B), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: raster position from cycle count, fill as a queue of accepted values.
  int unsigned m_t;
  logic [3:0]  m_disp [64];
  bit          m_known;
  logic [3:0]  m_fill [$];
  bit          m_underrun;
  logic [1:0]  e_r, e_g, e_b;
  logic        e_hs, e_vs, e_fs;
  bit          e_rgb_chk;
  bit          cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_rgb(input logic [3:0] d, output bit ok);
`ifdef VGA_PALETTE_EN
    ok = (d == 4'd0) || (d == 4'd15);
    return (d == 4'd15) ? 6'h3F : 6'h00;
`else
    ok = 1'b1;
    return {3{2'(d >> 2)}};
`endif
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    m_t = 0;
    m_fill.delete();
    m_underrun = 1'b0;
    m_known = 1'b0;
    {e_r, e_g, e_b} = 6'd0;
    e_hs = 1'b1;
    e_vs = 1'b1;
    e_fs = 1'b0;
    e_rgb_chk = 1'b1;
  endtask

  task automatic model_step();
    int unsigned h, v;
    bit full_before, swap, ok;
    logic [5:0] c;
    h = m_t % HT;
    v = (m_t / HT) % VT;
    e_hs = !(h >= HA + HFP && h < HA + HFP + HS);
    e_vs = !(v >= VA + VFP && v < VA + VFP + VS);
    e_fs = (h == 0 && v == VA);
    {e_r, e_g, e_b} = 6'd0;
    e_rgb_chk = 1'b1;
    if (h < HA && v < VA) begin
      if (m_known) begin
        c = exp_rgb(m_disp[h / PR], ok);
        {e_r, e_g, e_b} = c;
        e_rgb_chk = ok;
      end else begin
        e_rgb_chk = 1'b0;
      end
    end
    full_before = (m_fill.size() == 64);
    swap = (h == HA) && (v == VT - 1 || (v < VA - 1 && v % RR == RR - 1));
    if (e_fs) begin
      m_fill.delete();
      m_underrun = 1'b0;
    end else begin
      if (wr_valid && !full_before) m_fill.push_back(wr_data);
      if (swap) begin
        if (full_before) begin
          for (int i = 0; i < 64; i++) m_disp[i] = m_fill[i];
          m_known = 1'b1;
          m_fill.delete();
        end else begin
          m_underrun = 1'b1;
        end
      end
    end
    m_t++;
  endtask

  always @(posedge clk) if (rst_n) model_step();

  always @(negedge clk) begin
    if (cmp_en) begin
      if (e_rgb_chk) begin
        check("R", R, e_r);
        check("G", G, e_g);
        check("B", B, e_b);
      end
      check("hsync", hsync, e_hs);
      check("vsync", vsync, e_vs);
      check("frame_start", frame_start, e_fs);
      check("wr_ready", wr_ready, (m_fill.size() < 64));
      check("underrun", underrun, m_underrun);
    end
  end

  // Drive random writes (rate in percent) until the next cycle to be clocked is raster (h, v).
  task automatic drive_until(input int unsigned h, input int unsigned v, input int unsigned rate);
    int n = 0;
    while (!((m_t % HT) == h && ((m_t / HT) % VT) == v)) begin
      wr_valid = ($urandom_range(0, 99) < rate);
      wr_data  = 4'($urandom);
      @(negedge clk);
      n++;
      if (n > 3 * FRAME) begin
        checks++;
        errors++;
        $display("FAIL wait_raster: position (%0d,%0d) not reached, expected within %0d cycles", h, v, 3 * FRAME);
        return;
      end
    end
  endtask

  // Leaves the bench at the negedge where outputs reflect raster (h, v).
  task automatic sample_at(input int unsigned h, input int unsigned v);
    drive_until(h, v, 0);
    wr_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #(1500000 * 10);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int hs_low, vs_low, fs_cnt;
    do_reset();
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_rgb", {R, G, B}, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_underrun", underrun, 0);
    rst_n = 1'b1;

    // Idle free run: sync duty and frame pulses.
    hs_low = 0; vs_low = 0; fs_cnt = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (frame_start) fs_cnt++;
    end
    check("hsync_low_count", hs_low, 2 * VT * 12);
    check("vsync_low_count", vs_low, 2 * 2 * HT);
    check("frame_start_count", fs_cnt, 2);
    check("idle_underrun", underrun, 1);

    // Gray ramp written during vertical blanking, shown from line 0.
    drive_until(0, VA + 1, 0);
    for (int k = 0; k < 64; k++) begin
      wr_valid = 1'b1;
      wr_data = 4'(k % 16);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    sample_at(PR * 0, 0);
    check("ramp_col0", {R, G, B}, 0);
`ifndef VGA_PALETTE_EN
    sample_at(PR * 5, 0);
    check("ramp_col5", {R, G, B}, 6'b010101);
`endif
    sample_at(PR * 15, 1);
    check("ramp_col15", {R, G, B}, 6'b111111);
    sample_at(PR * 16, 2);
    check("ramp_col16", {R, G, B}, 0);
    sample_at(PR * 15, 3);
    check("repeat_old_row", {R, G, B}, 6'b111111);
    check("underrun_set", underrun, 1);
    drive_until(1, VA, 0);
    check("frame_start_pulse", frame_start, 1);
    check("underrun_cleared", underrun, 0);

    // Backpressure held across the end-of-frame swap.
    drive_until(HA, VT - 1, 100);
    check("bp_ready_before_swap", wr_ready, 0);
    wr_valid = 1'b1; wr_data = 4'($urandom);
    @(negedge clk);
    check("bp_ready_after_swap", wr_ready, 1);
    wr_valid = 1'b1; wr_data = 4'($urandom);
    @(negedge clk);
    wr_valid = 1'b0;

    // Last write coincides with a swap point: underrun now, swap at the next one.
    drive_until(1, VA, 0);
    drive_until(HA - 63, 2, 0);
    for (int k = 0; k < 64; k++) begin
      wr_valid = 1'b1;
      wr_data = 4'(15 - k % 16);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("coincident_underrun", underrun, 1);
    check("coincident_full", wr_ready, 0);
    sample_at(0, 6);
    check("late_swap_col0", {R, G, B}, 6'b111111);

    // A write on the frame-start cycle is dropped.
    drive_until(1, VA, 0);
    drive_until(HT - 2, VA - 1, 0);
    drive_until(64, VA, 100);
    check("fs_drop_ready_63", wr_ready, 1);
    wr_valid = 1'b1; wr_data = 4'($urandom);
    @(negedge clk);
    check("fs_drop_ready_64", wr_ready, 0);
    wr_valid = 1'b0;

    // Random traffic with a per-line write rate.
    for (int l = 0; l < 6 * VT; l++) begin
      int unsigned rate;
      rate = $urandom_range(0, 100);
      repeat (HT) begin
        wr_valid = ($urandom_range(0, 99) < rate);
        wr_data = 4'($urandom);
        @(negedge clk);
      end
    end
    wr_valid = 1'b0;

    // Asynchronous reset in the middle of the hsync pulse.
    drive_until(HA + HFP + 2, 1, 0);
    @(posedge clk);
    #2;
    check("pre_reset_hsync", hsync, 0);
    do_reset();
    #1;
    check("async_rst_hsync", hsync, 1);
    check("async_rst_vsync", vsync, 1);
    check("async_rst_rgb", {R, G, B}, 0);
    check("async_rst_fs", frame_start, 0);
    check("async_rst_underrun", underrun, 0);
    check("async_rst_ready", wr_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME) begin
      wr_valid = ($urandom_range(0, 99) < 60);
      wr_data = 4'($urandom);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
